// File: rtl/fetch_queue_if_if.sv
// Bundle of all non-clock/reset signals around the fetch_queue_if stage:
// hazard controls, EX redirect, instruction-memory port and the ID-facing
// queue head. The master modport is the fetch stage's view; slave is the
// view of the surrounding pipeline (hazard unit, EX, imem, ID).
// Optional macro FETCH_PERF_CNT_EN adds the two performance counters.
//
// Handshake: ID consumes the head in every cycle where o_valid_d=1 and
// i_if_id_stall_h=0; fetch writes a new entry in every cycle where
// i_pc_wr_en_h=1 and a slot is free (or is being freed by that dequeue).
interface fetch_queue_if_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) ();
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             i_clk_en;
  logic             i_pc_wr_en_h;
  logic             i_if_id_flush_h;
  logic             i_if_id_stall_h;
  logic             i_redirect_e;
  logic [XLEN-1:0]  i_redirect_pc_e;
  logic [XLEN-1:0]  o_imem_addr;
  logic [31:0]      i_imem_rdata;
  logic [31:0]      o_instr_d;
  logic [XLEN-1:0]  o_pc_d;
  logic [XLEN-1:0]  o_pc_plus4_d;
  logic             o_valid_d;
  logic [6:0]       o_opcode_d;
  logic [2:0]       o_f3_d;
  logic             o_f7_b6_d;
  logic [CNT_W-1:0] o_count;
  logic             o_full;
  logic             o_empty;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]      o_stall_cnt;
  logic [31:0]      o_flush_cnt;
`endif

  modport master (
    input  i_clk_en, i_pc_wr_en_h, i_if_id_flush_h, i_if_id_stall_h,
    input  i_redirect_e, i_redirect_pc_e, i_imem_rdata,
    output o_imem_addr, o_instr_d, o_pc_d, o_pc_plus4_d, o_valid_d,
    output o_opcode_d, o_f3_d, o_f7_b6_d, o_count, o_full, o_empty
`ifdef FETCH_PERF_CNT_EN
    , output o_stall_cnt, o_flush_cnt
`endif
  );

  modport slave (
    output i_clk_en, i_pc_wr_en_h, i_if_id_flush_h, i_if_id_stall_h,
    output i_redirect_e, i_redirect_pc_e, i_imem_rdata,
    input  o_imem_addr, o_instr_d, o_pc_d, o_pc_plus4_d, o_valid_d,
    input  o_opcode_d, o_f3_d, o_f7_b6_d, o_count, o_full, o_empty
`ifdef FETCH_PERF_CNT_EN
    , input o_stall_cnt, o_flush_cnt
`endif
  );
endinterface

// File: rtl/fetch_queue_if.sv
// IF stage: PC generator feeding a DEPTH-entry instruction queue that
// stands in for the IF/ID register. ID sees the queue head combinationally
// (NOP / PC 0 when empty). EX redirect and hazard flush clear the queue.
// Optional macro FETCH_PERF_CNT_EN adds saturating stall/flush counters.
module fetch_queue_if #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic               i_clk,
  input logic               i_rst,
  fetch_queue_if_if.master  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [XLEN-1:0]  r_pc;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [XLEN-1:0]  r_pc_q    [DEPTH];
  logic [31:0]      r_instr_q [DEPTH];

  logic             w_empty;
  logic             w_full;
  logic             w_deq;
  logic             w_enq;
  logic             w_clear;
  logic             w_write;
  logic [XLEN-1:0]  w_redirect_target;
  logic [XLEN-1:0]  w_head_pc;
  logic [31:0]      w_head_instr;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_deq   = !w_empty && !bus.i_if_id_stall_h;
  assign w_enq   = bus.i_pc_wr_en_h && (!w_full || w_deq);
  // Redirect or flush wipes the queue; neither enqueues that cycle.
  assign w_clear = bus.i_redirect_e || bus.i_if_id_flush_h;
  assign w_write = bus.i_clk_en && !i_rst && !w_clear && w_enq;
  // Instructions are word aligned, so the low two target bits are dropped.
  assign w_redirect_target = bus.i_redirect_pc_e & ~XLEN'(3);

  // PC, pointers and occupancy; reset wins, then redirect, then flush.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc     <= RESET_PC;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.i_clk_en) begin
      if (bus.i_redirect_e) begin
        r_pc     <= w_redirect_target;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else if (bus.i_if_id_flush_h) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_enq) begin
          r_pc     <= r_pc + XLEN'(4);
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        if (w_deq) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        case ({w_enq, w_deq})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Queue storage; contents are only meaningful below r_count, so no reset.
  always_ff @(posedge i_clk) begin
    if (w_write) begin
      r_pc_q[r_wr_ptr]    <= r_pc;
      r_instr_q[r_wr_ptr] <= bus.i_imem_rdata;
    end
  end

  assign w_head_pc    = w_empty ? '0  : r_pc_q[r_rd_ptr];
  assign w_head_instr = w_empty ? NOP : r_instr_q[r_rd_ptr];

  assign bus.o_imem_addr  = r_pc;
  assign bus.o_instr_d    = w_head_instr;
  assign bus.o_pc_d       = w_head_pc;
  assign bus.o_pc_plus4_d = w_head_pc + XLEN'(4);
  assign bus.o_valid_d    = !w_empty;
  assign bus.o_opcode_d   = w_head_instr[6:0];
  assign bus.o_f3_d       = w_head_instr[14:12];
  assign bus.o_f7_b6_d    = w_head_instr[30];
  assign bus.o_count      = r_count;
  assign bus.o_full       = w_full;
  assign bus.o_empty      = w_empty;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Saturating counts of ID stalls on a valid head and of non-empty clears.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (bus.i_clk_en) begin
      if (!w_empty && bus.i_if_id_stall_h && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_clear && !w_empty && (r_flush_cnt != 32'hFFFF_FFFF))
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign bus.o_stall_cnt = r_stall_cnt;
  assign bus.o_flush_cnt = r_flush_cnt;
`endif
endmodule
